// File: rtl/logic48_pattern_det.sv
`default_nettype none
// ============================================================================
// Module   : logic48_pattern_det
// Purpose  : Masked pattern / inverted-pattern detector for the 48-bit logic
//            unit result, with a 2-stage output pipeline and a saturating
//            per-frame match counter framed by SOF/EOF.
// Revision : 1.0 - initial release
// ============================================================================
module logic48_pattern_det #(
  parameter int                 WIDTH   = 48,
  parameter logic [WIDTH-1:0]   PATTERN = '0,
  parameter logic [WIDTH-1:0]   MASK    = '0,
  parameter int                 CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  DIN,
  input  logic              DIN_VLD,
  input  logic              SOF,
  input  logic              EOF,
  output logic [WIDTH-1:0]  DOUT,
  output logic              DOUT_VLD,
  output logic              PATTERN_DETECT,
  output logic              PATTERNB_DETECT,
  output logic              PATTERN_DETECT_PAST,
  output logic [CNT_W-1:0]  MATCH_CNT,
  output logic              CNT_VLD,
  output logic              CNT_SAT
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_INFRAME = 1'b1
  } state_t;

  // Stage 1 registers
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s1_vld;
  logic             r_s1_sof;
  logic             r_s1_eof;
  logic             r_s1_eq;
  logic             r_s1_eqb;

  // Stage 2 registers
  logic [WIDTH-1:0] r_s2_data;
  logic             r_s2_vld;
  logic             r_s2_pd;
  logic             r_s2_pbd;
  logic             r_s2_pd_past;

  // Frame counting state
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_cnt_vld;
  logic             r_cnt_sat;

  // Combinational helpers
  logic             w_eq;
  logic             w_eqb;
  logic             w_accept;
  logic             w_frame_end;
  logic [CNT_W-1:0] w_base_cnt;
  logic             w_base_sat;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sat_nxt;

  // Masked compare: a 1 in MASK removes that bit from the comparison.
  assign w_eq  = &(~(DIN ^ PATTERN)  | MASK);
  assign w_eqb = &(~(DIN ^ ~PATTERN) | MASK);

  // Stage 1: capture input word, qualifiers and compare results every cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s1_data <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_sof  <= 1'b0;
      r_s1_eof  <= 1'b0;
      r_s1_eq   <= 1'b0;
      r_s1_eqb  <= 1'b0;
    end else begin
      r_s1_data <= DIN;
      r_s1_vld  <= DIN_VLD;
      r_s1_sof  <= SOF;
      r_s1_eof  <= EOF;
      r_s1_eq   <= w_eq;
      r_s1_eqb  <= w_eqb;
    end
  end

  // Stage 2: data and flags advance only on valid words; bubbles hold them.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s2_data    <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_pd      <= 1'b0;
      r_s2_pbd     <= 1'b0;
      r_s2_pd_past <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data    <= r_s1_data;
        r_s2_pd      <= r_s1_eq;
        r_s2_pbd     <= r_s1_eqb;
        // r_s2_pd still holds the detect of the previous valid word here.
        r_s2_pd_past <= r_s2_pd;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and running count: SOF restarts the count from this word,
  // increments past the maximum stick at the max and set the sat bit.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = r_s1_vld && (r_s1_sof || (r_state == ST_INFRAME));
    w_frame_end = w_accept && r_s1_eof;
    w_base_cnt  = r_s1_sof ? '0   : r_cnt;
    w_base_sat  = r_s1_sof ? 1'b0 : r_sat;
    w_cnt_nxt   = w_base_cnt;
    w_sat_nxt   = w_base_sat;
    if (r_s1_eq) begin
      if (w_base_cnt == C_CNT_MAX) begin
        w_sat_nxt = 1'b1;
      end else begin
        w_cnt_nxt = w_base_cnt + 1'b1;
      end
    end
    if (w_accept) begin
      w_state_nxt = r_s1_eof ? ST_IDLE : ST_INFRAME;
    end
  end

  // Running counter and frame result registers; result holds between frames.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_match_cnt <= '0;
      r_cnt_vld   <= 1'b0;
      r_cnt_sat   <= 1'b0;
    end else begin
      r_cnt_vld <= w_frame_end;
      if (w_accept) begin
        r_cnt <= w_cnt_nxt;
        r_sat <= w_sat_nxt;
      end
      if (w_frame_end) begin
        r_match_cnt <= w_cnt_nxt;
        r_cnt_sat   <= w_sat_nxt;
      end
    end
  end

  assign DOUT                = r_s2_data;
  assign DOUT_VLD            = r_s2_vld;
  assign PATTERN_DETECT      = r_s2_pd;
  assign PATTERNB_DETECT     = r_s2_pbd;
  assign PATTERN_DETECT_PAST = r_s2_pd_past;
  assign MATCH_CNT           = r_match_cnt;
  assign CNT_VLD             = r_cnt_vld;
  assign CNT_SAT             = r_cnt_sat;

endmodule
`default_nettype wire

// File: tb/tb_logic48_pattern_det.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic48_pattern_det
// Purpose  : Directed self-checking bench for logic48_pattern_det
//            (PATTERN=48'h7D0, MASK=48'hF, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic48_pattern_det;

  localparam int         WIDTH = 48;
  localparam int         CNT_W = 4;
  localparam logic [47:0] PAT  = 48'h7D0;
  localparam logic [47:0] MSK  = 48'hF;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] DIN;
  logic             DIN_VLD;
  logic             SOF;
  logic             EOF;
  logic [WIDTH-1:0] DOUT;
  logic             DOUT_VLD;
  logic             PATTERN_DETECT;
  logic             PATTERNB_DETECT;
  logic             PATTERN_DETECT_PAST;
  logic [CNT_W-1:0] MATCH_CNT;
  logic             CNT_VLD;
  logic             CNT_SAT;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int base_pulses;

  logic48_pattern_det #(
    .WIDTH  (WIDTH),
    .PATTERN(PAT),
    .MASK   (MSK),
    .CNT_W  (CNT_W)
  ) u_dut (
    .CLK                (CLK),
    .RST                (RST),
    .DIN                (DIN),
    .DIN_VLD            (DIN_VLD),
    .SOF                (SOF),
    .EOF                (EOF),
    .DOUT               (DOUT),
    .DOUT_VLD           (DOUT_VLD),
    .PATTERN_DETECT     (PATTERN_DETECT),
    .PATTERNB_DETECT    (PATTERNB_DETECT),
    .PATTERN_DETECT_PAST(PATTERN_DETECT_PAST),
    .MATCH_CNT          (MATCH_CNT),
    .CNT_VLD            (CNT_VLD),
    .CNT_SAT            (CNT_SAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count CNT_VLD pulses, sampled away from the active edge.
  always @(negedge CLK) begin
    if (CNT_VLD) n_pulses = n_pulses + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input (called 1 time unit after a rising edge), then
  // advance to 1 time unit after the next rising edge.
  task automatic tick(input logic [47:0] d, input logic v, input logic s, input logic e);
    DIN     = d;
    DIN_VLD = v;
    SOF     = s;
    EOF     = e;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    tick(48'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RST     = 1'b0;
    DIN     = '0;
    DIN_VLD = 1'b0;
    SOF     = 1'b0;
    EOF     = 1'b0;
    @(posedge CLK);
    #1;

    // Reset held with toggling input
    tick(48'h7D0, 1'b1, 1'b1, 1'b0);
    tick(48'hFFFF_FFFF_F82C, 1'b1, 1'b0, 1'b1);
    tick(48'h7D3, 1'b1, 1'b1, 1'b1);
    check("rst_dout",     DOUT, 0);
    check("rst_dout_vld", DOUT_VLD, 0);
    check("rst_pd",       PATTERN_DETECT, 0);
    check("rst_pbd",      PATTERNB_DETECT, 0);
    check("rst_past",     PATTERN_DETECT_PAST, 0);
    check("rst_cnt",      MATCH_CNT, 0);
    check("rst_cnt_vld",  CNT_VLD, 0);
    check("rst_cnt_sat",  CNT_SAT, 0);
    RST = 1'b1;

    // Masked compare, pipelined back-to-back
    tick(48'h7D3, 1'b1, 1'b0, 1'b0);
    check("lat1_vld", DOUT_VLD, 0);
    tick(48'hFFFF_FFFF_F82C, 1'b1, 1'b0, 1'b0);
    check("w7d3_dout", DOUT, 48'h7D3);
    check("w7d3_vld",  DOUT_VLD, 1);
    check("w7d3_pd",   PATTERN_DETECT, 1);
    check("w7d3_pbd",  PATTERNB_DETECT, 0);
    check("w7d3_past", PATTERN_DETECT_PAST, 0);
    tick(48'h7C0, 1'b1, 1'b0, 1'b0);
    check("wf82c_dout", DOUT, 48'hFFFF_FFFF_F82C);
    check("wf82c_pd",   PATTERN_DETECT, 0);
    check("wf82c_pbd",  PATTERNB_DETECT, 1);
    check("wf82c_past", PATTERN_DETECT_PAST, 1);
    idle();
    check("w7c0_dout", DOUT, 48'h7C0);
    check("w7c0_pd",   PATTERN_DETECT, 0);
    check("w7c0_pbd",  PATTERNB_DETECT, 0);
    check("w7c0_past", PATTERN_DETECT_PAST, 0);
    idle();
    check("bub_vld",  DOUT_VLD, 0);
    check("bub_dout", DOUT, 48'h7C0);
    check("nofrm_cnt_vld", CNT_VLD, 0);

    // Four-word frame: 7D0 7C0 7DF 7D1 -> 3 matches
    base_pulses = n_pulses;
    tick(48'h7D0, 1'b1, 1'b1, 1'b0);
    tick(48'h7C0, 1'b1, 1'b0, 1'b0);
    tick(48'h7DF, 1'b1, 1'b0, 1'b0);
    tick(48'h7D1, 1'b1, 1'b0, 1'b1);
    check("frm_early_cnt_vld", CNT_VLD, 0);
    idle();
    check("frm_cnt_vld",  CNT_VLD, 1);
    check("frm_dout_vld", DOUT_VLD, 1);
    check("frm_dout",     DOUT, 48'h7D1);
    check("frm_cnt",      MATCH_CNT, 3);
    check("frm_sat",      CNT_SAT, 0);
    idle();
    check("frm_pulse_end", CNT_VLD, 0);
    check("frm_cnt_hold",  MATCH_CNT, 3);
    check("frm_pulses",    n_pulses - base_pulses, 1);

    // Bubbles and past flag
    tick(48'h7D0, 1'b1, 1'b0, 1'b0);
    idle();
    check("b1_dout", DOUT, 48'h7D0);
    check("b1_pd",   PATTERN_DETECT, 1);
    idle();
    check("gap_vld",  DOUT_VLD, 0);
    check("gap_pd",   PATTERN_DETECT, 1);
    check("gap_dout", DOUT, 48'h7D0);
    idle();
    check("gap2_vld", DOUT_VLD, 0);
    tick(48'h7C0, 1'b1, 1'b0, 1'b1);
    check("gap3_vld", DOUT_VLD, 0);
    idle();
    check("b2_dout", DOUT, 48'h7C0);
    check("b2_pd",   PATTERN_DETECT, 0);
    check("b2_past", PATTERN_DETECT_PAST, 1);
    check("idle_eof_ignored", CNT_VLD, 0);

    // Saturation: 20 matching words into a 4-bit counter
    tick(48'h7D0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 20; i++) begin
      tick(48'h7D0, 1'b1, 1'b0, (i == 19));
    end
    idle();
    check("sat_cnt_vld", CNT_VLD, 1);
    check("sat_cnt",     MATCH_CNT, 15);
    check("sat_flag",    CNT_SAT, 1);
    tick(48'h7D0, 1'b1, 1'b1, 1'b0);
    tick(48'h7C0, 1'b1, 1'b0, 1'b0);
    tick(48'h7D5, 1'b1, 1'b0, 1'b1);
    check("sat_hold_flag", CNT_SAT, 1);
    idle();
    check("post_sat_cnt_vld", CNT_VLD, 1);
    check("post_sat_cnt",     MATCH_CNT, 2);
    check("post_sat_flag",    CNT_SAT, 0);
    idle();

    // SOF mid-frame restarts the count
    base_pulses = n_pulses;
    tick(48'h7D0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(48'h7D0, 1'b1, 1'b0, 1'b0);
    tick(48'h7C0, 1'b1, 1'b1, 1'b0);
    tick(48'h7D0, 1'b1, 1'b0, 1'b1);
    idle();
    idle();
    check("abort_cnt",    MATCH_CNT, 1);
    check("abort_pulses", n_pulses - base_pulses, 1);

    // Reset mid-frame is asynchronous and abandons the frame
    base_pulses = n_pulses;
    tick(48'h7D0, 1'b1, 1'b1, 1'b0);
    tick(48'h7D0, 1'b1, 1'b0, 1'b0);
    tick(48'h7D0, 1'b1, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check("arst_dout",  DOUT, 0);
    check("arst_vld",   DOUT_VLD, 0);
    check("arst_pd",    PATTERN_DETECT, 0);
    check("arst_cnt",   MATCH_CNT, 0);
    @(posedge CLK);
    #1;
    idle();
    RST = 1'b1;
    tick(48'h7D0, 1'b1, 1'b0, 1'b1);
    idle();
    idle();
    check("arst_pulses",   n_pulses - base_pulses, 0);
    check("arst_cnt_post", MATCH_CNT, 0);
    check("arst_dout_vld_post", DOUT_VLD, 0);
    check("arst_dout_post", DOUT, 48'h7D0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
